// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among N_REQ writeback
// requesters (ALU pipe, load unit, mul/div, ...).
//
// Ports:
//   clk        posedge clock
//   reset      synchronous, active-low
//   hold       1 = grant nothing this cycle
//   req_valid  per-requester write pending
//   req_addr   per-requester destination register
//   req_data   per-requester write data
//   req_ready  combinational grant; transfer when req_valid[i] && req_ready[i]
//   W_addr     registered regfile write address
//   W_data     registered regfile write data
//   wr_enable  registered regfile write enable (low for writes to $0)
//   grant_id   registered index of the requester accepted last cycle
//   busy       something is pending but nobody was granted this cycle
module regfile_wb_arbiter #(
  parameter int unsigned width = 32,
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hold,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][4:0]       req_addr,
  input  logic [N_REQ-1:0][width-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [4:0]                  W_addr,
  output logic [width-1:0]            W_data,
  output logic                        wr_enable,
  output logic [PTR_W-1:0]            grant_id,
  output logic                        busy
);

  logic [PTR_W-1:0] rr_ptr_q;
  logic             grant_valid;
  logic [PTR_W-1:0] grant_idx;
  logic [4:0]       sel_addr;
  logic [width-1:0] sel_data;

  // Two passes: the first only looks at indices >= rr_ptr, the second takes the lowest
  // valid index overall, which covers the wrapped-around part of the scan.
  always_comb begin
    req_ready   = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sel_addr    = '0;
    sel_data    = '0;
    if (reset && !hold) begin
      for (int unsigned pass = 0; pass < 2; pass++) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
          if (!grant_valid && req_valid[i] && ((pass != 0) || (PTR_W'(i) >= rr_ptr_q))) begin
            grant_valid  = 1'b1;
            grant_idx    = PTR_W'(i);
            sel_addr     = req_addr[i];
            sel_data     = req_data[i];
            req_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  assign busy = (|req_valid) & ~(|req_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q  <= '0;
      W_addr    <= '0;
      W_data    <= '0;
      wr_enable <= 1'b0;
      grant_id  <= '0;
    end else begin
      wr_enable <= 1'b0;
      if (grant_valid) begin
        W_addr    <= sel_addr;
        W_data    <= sel_data;
        grant_id  <= grant_idx;
        // $0 writes are accepted but never reach the regfile
        wr_enable <= (sel_addr != 5'd0);
        // Served requester drops to lowest priority; wrap keeps rr_ptr below N_REQ
        rr_ptr_q  <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write scoreboard and a behavioural regfile.
module tb_regfile_wb_arbiter;
  localparam int unsigned W = 32;
  localparam int unsigned N = 3;
  localparam int unsigned P = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                hold;
  logic [N-1:0]        req_valid;
  logic [N-1:0][4:0]   req_addr;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic [4:0]          W_addr;
  logic [W-1:0]        W_data;
  logic                wr_enable;
  logic [P-1:0]        grant_id;
  logic                busy;

  regfile_wb_arbiter #(.width(W), .N_REQ(N), .PTR_W(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .W_addr    (W_addr),
    .W_data    (W_data),
    .wr_enable (wr_enable),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [W-1:0] rf [32] = '{default: '0};
  always @(posedge clk) if (wr_enable) rf[W_addr] <= W_data;

  typedef struct packed {
    logic         we;
    logic [4:0]   addr;
    logic [W-1:0] data;
    logic [P-1:0] id;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  rdy_cnt [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks req_ready against the expected one-hot and queues the write it implies.
  task automatic expect_ready(input string tag, input logic [N-1:0] exp_rdy);
    wr_t e;
    #1;
    chk({tag, " ready"}, 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < int'(N); i++) begin
      rdy_cnt[i] += int'(req_ready[i]);
      if (exp_rdy[i]) begin
        e.we   = (req_addr[i] != 5'd0);
        e.addr = req_addr[i];
        e.data = req_data[i];
        e.id   = P'(i);
        exp_q.push_back(e);
      end
    end
  endtask

  // Advances one clock and compares the registered write port with the scoreboard.
  task automatic tick(input string tag);
    wr_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " wr_enable"}, 64'(wr_enable), 64'(e.we));
      chk({tag, " W_addr"}, 64'(W_addr), 64'(e.addr));
      chk({tag, " W_data"}, 64'(W_data), 64'(e.data));
      chk({tag, " grant_id"}, 64'(grant_id), 64'(e.id));
    end else begin
      chk({tag, " idle wr_enable"}, 64'(wr_enable), 64'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) rdy_cnt[i] = 0;
    reset     = 1'b0;
    hold      = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

    // 1. reset blocks all grants and clears the output stage
    expect_ready("rst", 3'b000);
    @(posedge clk);
    #1;
    chk("rst wr_enable", 64'(wr_enable), 64'd0);
    chk("rst W_addr", 64'(W_addr), 64'd0);
    chk("rst W_data", 64'(W_data), 64'd0);
    chk("rst grant_id", 64'(grant_id), 64'd0);
    @(negedge clk);

    // 2. single request
    reset       = 1'b1;
    req_valid   = 3'b010;
    req_addr[1] = 5'd9;
    req_data[1] = 32'hDEAD_BEEF;
    expect_ready("single", 3'b010);
    chk("single busy", 64'(busy), 64'd0);
    tick("single");
    req_valid = 3'b000;
    expect_ready("single idle", 3'b000);
    chk("idle busy", 64'(busy), 64'd0);
    tick("single idle");
    chk("r9 readback", 64'(rf[9]), 64'hDEAD_BEEF);

    // 3. fairness from reset
    reset = 1'b0;
    tick("rst2");
    reset     = 1'b1;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_valid = 3'b111;
    for (int i = 0; i < int'(N); i++) rdy_cnt[i] = 0;
    expect_ready("rr0", 3'b001); tick("rr0");
    expect_ready("rr1", 3'b010); tick("rr1");
    expect_ready("rr2", 3'b100); tick("rr2");
    expect_ready("rr3", 3'b001); tick("rr3");
    expect_ready("rr4", 3'b010); tick("rr4");
    expect_ready("rr5", 3'b100); tick("rr5");
    chk("ready0 count", 64'(rdy_cnt[0]), 64'd2);
    chk("ready1 count", 64'(rdy_cnt[1]), 64'd2);
    chk("ready2 count", 64'(rdy_cnt[2]), 64'd2);
    req_valid = 3'b000;
    expect_ready("rr flush", 3'b000);
    tick("rr flush");

    // 5. hold freezes grants and pointer (rr_ptr is 0 here)
    req_valid = 3'b011;
    hold      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      expect_ready("hold", 3'b000);
      chk("hold busy", 64'(busy), 64'd1);
      tick("hold");
    end
    hold = 1'b0;
    expect_ready("post hold 0", 3'b001);
    tick("post hold 0");
    req_valid = 3'b010;
    expect_ready("post hold 1", 3'b010);
    tick("post hold 1");

    // 4. write to $0 is accepted but not enabled
    req_valid   = 3'b001;
    req_addr[0] = 5'd0;
    req_data[0] = 32'h0000_1234;
    expect_ready("r0 write", 3'b001);
    tick("r0 write");
    req_valid = 3'b000;
    expect_ready("r0 idle", 3'b000);
    tick("r0 idle");
    chk("r0 readback", 64'(rf[0]), 64'd0);

    // 6. reset mid-stream; all target r7 so the last grant decides its value
    req_addr  = {5'd7, 5'd7, 5'd7};
    req_data  = {32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
    req_valid = 3'b111;
    expect_ready("mid 1", 3'b010); tick("mid 1");
    expect_ready("mid 2", 3'b100); tick("mid 2");
    reset = 1'b0;
    expect_ready("mid rst", 3'b000);
    tick("mid rst");
    chk("mid rst grant_id", 64'(grant_id), 64'd0);
    reset = 1'b1;
    expect_ready("after rst", 3'b001);
    tick("after rst");
    req_valid = 3'b000;
    expect_ready("final idle", 3'b000);
    tick("final idle");
    chk("r7 last writer", 64'(rf[7]), 64'h7777_0000);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
